// File: rtl/nn_pkg.sv
// Shared definitions for the dense-layer datapath: Q8.8 word format,
// activation encodings and the stream bridge state encoding.
package nn_pkg;

    localparam int unsigned DATA_WIDTH = 16;
    localparam int unsigned DATA_FRAC  = 8;

    localparam int unsigned ACT_NONE  = 0;
    localparam int unsigned ACT_RELU  = 1;
    localparam int unsigned ACT_LEAKY = 2;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_COLLECT  = 3'd0,
        S_WAIT_DST = 3'd1,
        S_START    = 3'd2,
        S_STREAM   = 3'd3,
        S_DONE     = 3'd4
    } bridge_state_t;

endpackage

// File: rtl/nn_activation.sv
// Combinational activation on a signed fixed-point word (identity, ReLU or
// LeakyReLU with a power-of-two negative slope).
module nn_activation
    import nn_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = nn_pkg::DATA_WIDTH,
    parameter int unsigned ACT_MODE    = ACT_NONE,
    parameter int unsigned LEAKY_SHIFT = 3
) (
    input  logic signed [DATA_WIDTH-1:0] i_x,
    output logic signed [DATA_WIDTH-1:0] o_y_c
);

    logic w_neg;

    // Arithmetic shift floors toward negative infinity for negative inputs.
    always_comb begin
        w_neg = i_x[DATA_WIDTH-1];
        o_y_c = i_x;
        if (ACT_MODE == ACT_RELU) begin
            if (w_neg) o_y_c = '0;
        end else if (ACT_MODE == ACT_LEAKY) begin
            if (w_neg) o_y_c = i_x >>> LEAKY_SHIFT;
        end
    end

endmodule

// File: rtl/vector_stream_bridge.sv
// Collects an indexed upstream result stream into a vector buffer, then hands
// it to the downstream layer as a start pulse followed by an in-order stream.
module vector_stream_bridge
    import nn_pkg::*;
#(
    parameter int unsigned VEC_SIZE    = 3,
    parameter int unsigned DATA_WIDTH  = nn_pkg::DATA_WIDTH,
    parameter int unsigned ACT_MODE    = ACT_RELU,
    parameter int unsigned LEAKY_SHIFT = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic signed [DATA_WIDTH-1:0]  in_data,
    input  logic                          in_valid,
    input  logic [$clog2(VEC_SIZE)-1:0]   in_idx,
    input  logic                          dst_busy,
    output logic                          out_start,
    output logic signed [DATA_WIDTH-1:0]  out_data,
    output logic                          out_valid,
    output logic                          busy,
    output logic                          done,
    output logic                          err
);

    localparam int unsigned IDX_W = $clog2(VEC_SIZE);
    localparam int unsigned CNT_W = $clog2(VEC_SIZE + 1);
    localparam logic [VEC_SIZE-1:0] FILL_FULL = '1;

    bridge_state_t r_state;
    bridge_state_t w_state_n;

    logic [VEC_SIZE-1:0]   r_fill;
    logic [VEC_SIZE-1:0]   w_fill_n;
    logic [VEC_SIZE-1:0]   w_idx_1h;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_cnt_n;
    logic [DATA_WIDTH-1:0] r_buf [VEC_SIZE];
    logic signed [DATA_WIDTH-1:0] w_act;
    logic [DATA_WIDTH-1:0] w_data_n;

    logic w_idx_ok;
    logic w_wr;
    logic w_err_set;
    logic w_start_n;
    logic w_valid_n;
    logic w_done_n;
    logic w_busy_n;

    logic                  r_out_start;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_out_valid;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_err;

    nn_activation #(
        .DATA_WIDTH  (DATA_WIDTH),
        .ACT_MODE    (ACT_MODE),
        .LEAKY_SHIFT (LEAKY_SHIFT)
    ) u_act (
        .i_x   (in_data),
        .o_y_c (w_act)
    );

    // Capture qualification: only in-range indices while collecting are written.
    always_comb begin
        w_idx_ok  = 32'(in_idx) < VEC_SIZE;
        w_wr      = in_valid && w_idx_ok && (r_state == S_COLLECT);
        w_err_set = in_valid && !w_wr;
        w_idx_1h  = '0;
        if (w_idx_ok) w_idx_1h[in_idx] = 1'b1;
    end

    // Next-state and registered-output decode.
    always_comb begin
        w_state_n = r_state;
        w_fill_n  = r_fill;
        w_cnt_n   = r_cnt;
        w_data_n  = r_out_data;
        case (r_state)
            S_COLLECT: begin
                if (w_wr) begin
                    w_fill_n = r_fill | w_idx_1h;
                    if (w_fill_n == FILL_FULL) w_state_n = S_WAIT_DST;
                end
            end
            S_WAIT_DST: begin
                if (!dst_busy) begin
                    w_state_n = S_START;
                    w_cnt_n   = '0;
                end
            end
            S_START: begin
                w_state_n = S_STREAM;
                w_data_n  = r_buf[IDX_W'(r_cnt)];
                w_cnt_n   = r_cnt + CNT_W'(1);
            end
            S_STREAM: begin
                if (r_cnt == CNT_W'(VEC_SIZE)) begin
                    w_state_n = S_DONE;
                end else begin
                    w_data_n = r_buf[IDX_W'(r_cnt)];
                    w_cnt_n  = r_cnt + CNT_W'(1);
                end
            end
            S_DONE: begin
                w_state_n = S_COLLECT;
                w_fill_n  = '0;
            end
            default: begin
                w_state_n = S_COLLECT;
                w_fill_n  = '0;
            end
        endcase

        w_start_n = (w_state_n == S_START);
        w_valid_n = (w_state_n == S_STREAM);
        w_done_n  = (w_state_n == S_DONE);
        w_busy_n  = (w_state_n == S_WAIT_DST) || (w_state_n == S_START) ||
                    (w_state_n == S_STREAM);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_COLLECT;
            r_fill      <= '0;
            r_cnt       <= '0;
            r_out_start <= 1'b0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_fill      <= w_fill_n;
            r_cnt       <= w_cnt_n;
            r_out_start <= w_start_n;
            r_out_data  <= w_data_n;
            r_out_valid <= w_valid_n;
            r_busy      <= w_busy_n;
            r_done      <= w_done_n;
            r_err       <= r_err | w_err_set;
        end
    end

    // Vector storage needs no reset; the fill mask gates its use.
    always_ff @(posedge clk) begin
        if (w_wr) r_buf[in_idx] <= w_act;
    end

    assign out_start = r_out_start;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;

endmodule

// File: doc/vector_stream_bridge.md
Name: vector_stream_bridge

Overview:
- Sits between two dense layers and joins them.
- Collects the upstream layer's indexed, sequential output stream (data word, valid, output index) into a vector buffer, applying an optional activation on capture.
- Once the vector is complete, it issues a one-cycle start to the downstream layer and streams the vector in index order on a data/valid pair.
- This is the transmitter that matches the dense layer's start/data_in/data_valid receiver.

Parameters:
- VEC_SIZE, 3, number of vector elements (equals upstream OUT_SIZE and downstream IN_SIZE).
- DATA_WIDTH, 16, Q8.8 signed word width.
- ACT_MODE, 1, activation applied on capture: 0 = identity, 1 = ReLU, 2 = LeakyReLU.
- LEAKY_SHIFT, 3, LeakyReLU negative slope of 2^-LEAKY_SHIFT.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_data  in  DATA_WIDTH  signed upstream result.
- in_valid  in  1  in_data/in_idx valid this cycle.
- in_idx  in  $clog2(VEC_SIZE)  element index of in_data.
- dst_busy  in  1  downstream layer busy.
- out_start  out  1  one-cycle start pulse to downstream.
- out_data  out  DATA_WIDTH  signed streamed element.
- out_valid  out  1  out_data valid.
- busy  out  1  high from vector-complete until done.
- done  out  1  one-cycle pulse after last element is streamed.
- err  out  1  sticky protocol error flag.

Behaviour:
- Reset (clk edge with rst=1) clears all outputs to 0, clears the fill mask, sets state S_COLLECT and clears err. Buffer contents are don't-care. Reset mid-stream aborts immediately; no further out_valid is issued.
- States: S_COLLECT, S_WAIT_DST, S_START, S_STREAM, S_DONE.
- S_COLLECT:
  - On in_valid with in_idx < VEC_SIZE: buf[in_idx] <= act(in_data) and fill[in_idx] <= 1.
  - A duplicate index overwrites the element silently.
  - in_idx >= VEC_SIZE: the write is dropped and err is set.
  - When the mask including the current write is all ones, go to S_WAIT_DST on the next edge and set busy.
- Activation, combinational on the capture path, result width DATA_WIDTH:
  - ACT_MODE 0: x.
  - ACT_MODE 1: x<0 ? 0 : x.
  - ACT_MODE 2: x<0 ? (x >>> LEAKY_SHIFT) : x, arithmetic shift that floors toward negative infinity.
- S_WAIT_DST: stay while dst_busy=1; when dst_busy=0 go to S_START.
- S_START:
  - out_start=1 for exactly this cycle; load stream counter to 0.
  - Go to S_STREAM.
- S_STREAM:
  - out_valid=1 and out_data=buf[cnt] on VEC_SIZE consecutive cycles, cnt = 0..VEC_SIZE-1.
  - The first valid is in the cycle immediately after the out_start cycle; there are no gaps.
  - After the last element go to S_DONE.
- S_DONE:
  - done=1 for one cycle; busy cleared; fill mask cleared.
  - Return to S_COLLECT. A new in_valid is accepted from the following cycle.
- in_valid in any state other than S_COLLECT: the data is dropped and err is set. This is a single-buffer design; upstream must not produce until done.
- out_data holds its last value when out_valid=0. out_start, out_valid and done are mutually exclusive.
- Latency: last fill write at edge E, then out_start in cycle E+1 when dst_busy=0. First out_valid is at E+2, last at E+1+VEC_SIZE, done at E+2+VEC_SIZE.
- err is cleared only by rst.

Decomposition:
- Shared package (nn_pkg): Q8.8 DATA_WIDTH/DATA_FRAC constants, ACT_MODE encodings (ACT_NONE, ACT_RELU, ACT_LEAKY), state encoding localparams.
- One natural sub-module: nn_activation, a combinational act(x) parameterised by ACT_MODE and LEAKY_SHIFT, reusable by other layers.

Test Plan:
- ACT_MODE=0, writes idx 0,1,2 = 16'h0100, 16'hFF00, 16'h0080 with dst_busy=0 -> out_start one cycle after the third write. out_valid for 3 cycles with data 0100, FF00, 0080. done on the next cycle; busy falls with done.
- ACT_MODE=1, writes idx 2,0,1 out of order = FE00, 0300, 8000 -> stream 0300, 0000, 0000 in index order.
- ACT_MODE=2, LEAKY_SHIFT=3, writes 0 = FF00 (-1.0), 1 = FFF9, 2 = 0200 -> stream FFE0, FFFF, 0200.
- Vector completes with dst_busy=1 held 5 cycles -> no out_start until the cycle after dst_busy falls. Then normal stream follows.
- Faults: duplicate idx 1 write (second value streamed, err stays 0); in_idx=3 (dropped, err=1); in_valid during S_STREAM (ignored, stream unchanged, err=1).
- rst asserted on the second out_valid cycle -> next cycle all outputs 0 and err=0. A fresh 3-element fill streams correctly.
